// File: rtl/cga_pkg.sv
// Shared types and constants for the CGA ISA-side VRAM port: default widths,
// access FSM encoding and the sequencer's CPU grant windows.
package cga_pkg;

  localparam int AW_DEF = 14;
  localparam int DW_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    A1,
    A2,
    DONE
  } state_t;

  // clkdiv ranges in which the sequencer opens isa_op_enable
  localparam int CLKDIV_PERIOD = 32;
  localparam int ISA_WIN0_LO   = 5;
  localparam int ISA_WIN0_HI   = 14;
  localparam int ISA_WIN1_LO   = 21;
  localparam int ISA_WIN1_HI   = 30;

  function automatic logic in_isa_window(input int clkdiv);
    return ((clkdiv >= ISA_WIN0_LO) && (clkdiv <= ISA_WIN0_HI)) ||
           ((clkdiv >= ISA_WIN1_LO) && (clkdiv <= ISA_WIN1_HI));
  endfunction

endpackage

// File: rtl/cga_isa_vram_port.sv
// CPU-side responder for the CGA VRAM time-slot scheme: runs one ISA access per
// sequencer grant and stretches ISA ready until it completes.
// Optional CGA_POSTED_WRITE_EN adds a one-entry posted write buffer.
module cga_isa_vram_port
  import cga_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          isa_op_enable,
  input  logic          vram_read,
  input  logic [AW-1:0] bus_addr,
  input  logic [DW-1:0] bus_din,
  input  logic          bus_memr,
  input  logic          bus_memw,
  output logic [DW-1:0] bus_dout,
  output logic          bus_rdy,
  output logic          cpu_sel,
  output logic [AW-1:0] cpu_addr,
  output logic          cpu_we,
  output logic [DW-1:0] cpu_wdata,
  input  logic [DW-1:0] vram_rdata,
  output logic          collision
);

  state_t        state;
  logic          req;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          wr_q;
  logic          full;
  logic          fresh;
  logic [AW-1:0] grant_addr;
  logic [DW-1:0] grant_data;
  logic          grant_wr;

  assign req = bus_memr | bus_memw;

  // A buffered write must drain before a new request may be captured.
  assign fresh      = (state == IDLE) && !full;
  assign grant_addr = fresh ? bus_addr : addr_q;
  assign grant_data = fresh ? bus_din  : data_q;
  assign grant_wr   = fresh ? bus_memw : wr_q;

`ifdef CGA_POSTED_WRITE_EN
  logic post_take;

  assign post_take = fresh && bus_memw;
  assign bus_rdy   = !(req && (state != DONE)) || post_take;
`else
  assign full    = 1'b0;
  assign bus_rdy = !(req && (state != DONE));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cpu_sel   <= 1'b0;
      cpu_we    <= 1'b0;
      cpu_addr  <= '0;
      cpu_wdata <= '0;
      bus_dout  <= '0;
      collision <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
`ifdef CGA_POSTED_WRITE_EN
      full      <= 1'b0;
`endif
    end else begin
      cpu_we    <= 1'b0;
      collision <= cpu_sel & vram_read;
      case (state)
        IDLE: begin
          if (full || req) begin
            if (fresh) begin
              addr_q <= bus_addr;
              data_q <= bus_din;
              wr_q   <= bus_memw;
            end
`ifdef CGA_POSTED_WRITE_EN
            if (post_take) begin
              full  <= 1'b1;
              state <= DONE;
            end else
`endif
            if (isa_op_enable) begin
              state     <= A1;
              cpu_sel   <= 1'b1;
              cpu_addr  <= grant_addr;
              cpu_wdata <= grant_data;
              cpu_we    <= grant_wr;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (isa_op_enable) begin
            state     <= A1;
            cpu_sel   <= 1'b1;
            cpu_addr  <= grant_addr;
            cpu_wdata <= grant_data;
            cpu_we    <= grant_wr;
          end
        end
        A1: state <= A2;
        A2: begin
          cpu_sel <= 1'b0;
          if (!wr_q) bus_dout <= vram_rdata;
`ifdef CGA_POSTED_WRITE_EN
          // a drain has no ISA cycle waiting on it, so skip DONE
          if (full) begin
            full  <= 1'b0;
            state <= IDLE;
          end else
`endif
          state <= DONE;
        end
        DONE: if (!req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cga_isa_vram_port.sv
// Scoreboard bench for cga_isa_vram_port: 32-cycle clkdiv sequencer model,
// synchronous VRAM model and a reference memory for expected read data.
module tb_cga_isa_vram_port;

  localparam int AW = 14;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          isa_op_enable;
  logic          vram_read;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_din;
  logic          bus_memr;
  logic          bus_memw;
  logic [DW-1:0] bus_dout;
  logic          bus_rdy;
  logic          cpu_sel;
  logic [AW-1:0] cpu_addr;
  logic          cpu_we;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] vram_rdata;
  logic          collision;

  int   clkdiv   = 0;
  logic force_vr = 1'b0;
  int   coll_cnt = 0;
  int   total    = 0;
  int   bad      = 0;

  logic [DW-1:0] vram    [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  typedef struct {
    bit            rd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;
  exp_t sb[$];

  cga_isa_vram_port #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .isa_op_enable(isa_op_enable),
    .vram_read    (vram_read),
    .bus_addr     (bus_addr),
    .bus_din      (bus_din),
    .bus_memr     (bus_memr),
    .bus_memw     (bus_memw),
    .bus_dout     (bus_dout),
    .bus_rdy      (bus_rdy),
    .cpu_sel      (cpu_sel),
    .cpu_addr     (cpu_addr),
    .cpu_we       (cpu_we),
    .cpu_wdata    (cpu_wdata),
    .vram_rdata   (vram_rdata),
    .collision    (collision)
  );

  always #5 clk = ~clk;

  function automatic bit en_at(input int d);
    return ((d >= 5) && (d <= 14)) || ((d >= 21) && (d <= 30));
  endfunction

  function automatic bit vr_at(input int d);
    return ((d >= 18) && (d <= 20)) || ((d >= 2) && (d <= 4));
  endfunction

  function automatic int grant_of(input int d);
    for (int k = 0; k < 32; k++)
      if (en_at((d + k) % 32)) return d + k;
    return d;
  endfunction

  always @(posedge clk) clkdiv <= (clkdiv + 1) % 32;
  assign isa_op_enable = en_at(clkdiv);
  assign vram_read     = vr_at(clkdiv) | force_vr;

  always @(posedge clk) begin
    if (cpu_we) vram[cpu_addr] <= cpu_wdata;
    vram_rdata <= vram[cpu_addr];
  end

  always @(negedge clk) if (collision) coll_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_div(input int d);
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      if (clkdiv == d) return;
    end
    check("wait_div", 32'(clkdiv), 32'(d));
  endtask

  // One ISA access starting in clkdiv slot div; timing expectations from the grant model.
  task automatic access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int div, input string tag);
    int          g, lat;
    logic [31:0] sel_m, we_m, exp_sel, exp_we;
    bit          got;
    exp_t        e, p;
    g       = grant_of(div);
    exp_sel = '0;
    exp_sel[(g + 1) % 32] = 1'b1;
    exp_sel[(g + 2) % 32] = 1'b1;
    exp_we  = '0;
    if (wr) exp_we[(g + 1) % 32] = 1'b1;
    wait_div(div);
    e.rd = !wr;
    e.a  = a;
    e.d  = wr ? d : ref_mem[a];
    if (wr) ref_mem[a] = d;
    sb.push_back(e);
    bus_addr = a;
    bus_din  = d;
    bus_memw = wr;
    bus_memr = !wr;
    lat   = 0;
    sel_m = '0;
    we_m  = '0;
    got   = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (cpu_sel) sel_m[clkdiv] = 1'b1;
      if (cpu_we)  we_m[clkdiv]  = 1'b1;
      if (bus_rdy) got = 1'b1;
      else lat++;
    end
    if (got && lat == 0) begin
      @(posedge clk);
      #1;
    end
    bus_memw = 1'b0;
    bus_memr = 1'b0;
    check({tag, "_rdy"}, 32'(got), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(g - div + 3));
    check({tag, "_sel"}, sel_m, exp_sel);
    check({tag, "_we"},  we_m,  exp_we);
    p = sb.pop_front();
    if (p.rd) check({tag, "_dout"}, 32'(bus_dout), 32'(p.d));
    else      check({tag, "_ram"},  32'(vram[p.a]), 32'(p.d));
  endtask

  logic [AW-1:0] ra [4];
  logic [DW-1:0] old;
  int            c0, lat;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      vram[i]    = 8'(i) ^ 8'h3C;
      ref_mem[i] = 8'(i) ^ 8'h3C;
    end
    vram[14'h0123]    = 8'h5A;
    ref_mem[14'h0123] = 8'h5A;
    reset    = 1'b1;
    bus_addr = '0;
    bus_din  = '0;
    bus_memr = 1'b0;
    bus_memw = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdy",  32'(bus_rdy),   32'd1);
    check("rst_sel",  32'(cpu_sel),   32'd0);
    check("rst_we",   32'(cpu_we),    32'd0);
    check("rst_dout", 32'(bus_dout),  32'd0);
    check("rst_coll", 32'(collision), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

`ifdef CGA_POSTED_WRITE_EN
    // posted write at clkdiv 2, read of the same byte at clkdiv 4
    wait_div(2);
    bus_addr = 14'h0042;
    bus_din  = 8'h11;
    bus_memw = 1'b1;
    ref_mem[14'h0042] = 8'h11;
    @(negedge clk);
    check("pw_rdy", 32'(bus_rdy), 32'd1);
    @(posedge clk);
    #1 bus_memw = 1'b0;
    @(posedge clk);
    #1;
    sb.push_back('{rd: 1'b1, a: 14'h0042, d: ref_mem[14'h0042]});
    bus_memr = 1'b1;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_rdy) break;
      lat++;
    end
    bus_memr = 1'b0;
    check("pr_lat", 32'(lat), 32'd7);
    begin
      exp_t p;
      p = sb.pop_front();
      check("pr_dout", 32'(bus_dout), 32'(p.d));
    end
`else
    access(1'b0, 14'h0123, 8'h00, 6,  "rd6");
    access(1'b1, 14'h3FFF, 8'hA5, 10, "wr10");
    check("dout_hold", 32'(bus_dout), 32'h5A);
    access(1'b0, 14'h0200, 8'h00, 15, "rd15");
    access(1'b0, 14'h3FFF, 8'h00, 14, "rd14");
    for (int i = 0; i < 4; i++) begin
      ra[i] = 14'($urandom_range(0, (1 << AW) - 1));
      access(1'b1, ra[i], 8'($urandom), int'($urandom_range(0, 31)), "wr_rnd");
    end
    for (int i = 0; i < 4; i++)
      access(1'b0, ra[i], 8'h00, int'($urandom_range(0, 31)), "rd_rnd");
    check("no_collision", 32'(coll_cnt), 32'd0);

    // reset in A1 of a write
    old = ref_mem[14'h0100];
    wait_div(6);
    bus_addr = 14'h0100;
    bus_din  = 8'h77;
    bus_memw = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("a1_we", 32'(cpu_we), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_a1_we",   32'(cpu_we),   32'd0);
    check("rst_a1_sel",  32'(cpu_sel),  32'd0);
    check("rst_a1_addr", 32'(cpu_addr), 32'd0);
    check("rst_a1_dout", 32'(bus_dout), 32'd0);
    check("rst_a1_rdy",  32'(bus_rdy),  32'd0);
    bus_memw = 1'b0;
    #1;
    check("rst_a1_rdy2", 32'(bus_rdy), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    check("rst_no_wr", 32'(vram[14'h0100]), 32'(old));
    access(1'b0, 14'h0100, 8'h00, 8, "rd_after_rst");

    // forced display-fetch overlap must raise collision for both A1 and A2
    c0 = coll_cnt;
    force_vr = 1'b1;
    access(1'b0, 14'h0123, 8'h00, 6, "rd_coll");
    @(negedge clk);
    force_vr = 1'b0;
    check("coll_pulses", 32'(coll_cnt - c0), 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
